// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select codes,
// scoreboard entry layout and the hazard classification used to drive enables.
package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Entry layout, LSB first: mem_access, mem_to_reg, reg_write, dst[REG_AW], valid
   localparam int SB_MA_BIT  = 0;
   localparam int SB_MTR_BIT = 1;
   localparam int SB_RW_BIT  = 2;
   localparam int SB_DST_LSB = 3;
   localparam int SB_CTL_W   = 4;

   typedef enum logic [2:0] {
      HZ_RESET    = 3'd0,
      HZ_FREEZE   = 3'd1,
      HZ_BRANCH   = 3'd2,
      HZ_LOAD_USE = 3'd3,
      HZ_JUMP     = 3'd4,
      HZ_NONE     = 3'd5
   } hazard_e;

   function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
      logic [1:0] sel;
      if (ex_hit) begin
         sel = FWD_MEM;
      end else if (mem_hit) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_REG;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID-stage control fields, resolution inputs and pipeline control outputs
// exchanged between the decode side (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_dst;
   logic              id_reg_write;
   logic              id_mem_to_reg;
   logic              id_mem_access;
   logic              id_jump;
   logic              ex_branch_taken;
   logic              dmem_ready;

   logic              pc_en;
   logic              ifid_en;
   logic              ifid_flush;
   logic              idex_en;
   logic              idex_flush;
   logic              exmem_en;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [CNT_W-1:0]  stall_cycles;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write,
             id_mem_to_reg, id_mem_access, id_jump, ex_branch_taken, dmem_ready,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             fwd_a, fwd_b, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write,
             id_mem_to_reg, id_mem_access, id_jump, ex_branch_taken, dmem_ready,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             fwd_a, fwd_b, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_sb_stage.sv
// One scoreboard entry: an enable-gated register with synchronous clear,
// chained three deep by the controller to shadow EX, MEM and WB.
module hazard_sb_stage #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Entry register; clear takes priority over a pipeline advance
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= {W{1'b0}};
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: tracks EX/MEM/WB
// destinations and drives stage enables, flushes, bubbles and forwarding selects.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam int SB_W     = REG_AW + SB_CTL_W;
   localparam int SB_V_BIT = REG_AW + SB_DST_LSB;

   logic [SB_W-1:0]   sb_d_s [3];
   logic [SB_W-1:0]   sb_r   [3];

   logic              ex_valid_s, ex_rw_s, ex_mtr_s;
   logic [REG_AW-1:0] ex_dst_s;
   logic              mem_valid_s, mem_rw_s, mem_ma_s;
   logic [REG_AW-1:0] mem_dst_s;

   logic              freeze_s, ld_hit_s, issue_s, adv_en_s;
   hazard_e           hz_sel_s;
   logic              pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_en_s;
   logic [1:0]        fwd_a_d_s, fwd_b_d_s;
   logic [1:0]        fwd_a_r, fwd_b_r;
   logic [CNT_W-1:0]  stall_r;

   function automatic logic src_hit(input logic valid, input logic rw,
                                    input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] src);
      return valid & rw & (dst != {REG_AW{1'b0}}) & (dst == src);
   endfunction

   assign ex_valid_s  = sb_r[0][SB_V_BIT];
   assign ex_rw_s     = sb_r[0][SB_RW_BIT];
   assign ex_mtr_s    = sb_r[0][SB_MTR_BIT];
   assign ex_dst_s    = sb_r[0][SB_DST_LSB +: REG_AW];
   assign mem_valid_s = sb_r[1][SB_V_BIT];
   assign mem_rw_s    = sb_r[1][SB_RW_BIT];
   assign mem_ma_s    = sb_r[1][SB_MA_BIT];
   assign mem_dst_s   = sb_r[1][SB_DST_LSB +: REG_AW];

   // Hazard classification in priority order; reset overrides everything
   always_comb begin
      freeze_s = mem_valid_s & mem_ma_s & ~hz.dmem_ready;
      ld_hit_s = ex_valid_s & ex_mtr_s & (ex_dst_s != {REG_AW{1'b0}})
               & ((ex_dst_s == hz.id_rs) | (hz.id_uses_rt & (ex_dst_s == hz.id_rt)));
      if (rst) begin
         hz_sel_s = HZ_RESET;
      end else if (freeze_s) begin
         hz_sel_s = HZ_FREEZE;
      end else if (ex_valid_s & hz.ex_branch_taken) begin
         hz_sel_s = HZ_BRANCH;
      end else if (hz.id_valid & ld_hit_s) begin
         hz_sel_s = HZ_LOAD_USE;
      end else if (hz.id_valid & hz.id_jump) begin
         hz_sel_s = HZ_JUMP;
      end else begin
         hz_sel_s = HZ_NONE;
      end
   end

   // Stage enables and flushes for each hazard class
   always_comb begin
      pc_en_s      = 1'b1;
      ifid_en_s    = 1'b1;
      ifid_flush_s = 1'b0;
      idex_en_s    = 1'b1;
      idex_flush_s = 1'b0;
      exmem_en_s   = 1'b1;
      case (hz_sel_s)
         HZ_RESET: begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            ifid_flush_s = 1'b1;
            idex_en_s    = 1'b0;
            idex_flush_s = 1'b1;
            exmem_en_s   = 1'b0;
         end
         HZ_FREEZE: begin
            pc_en_s    = 1'b0;
            ifid_en_s  = 1'b0;
            idex_en_s  = 1'b0;
            exmem_en_s = 1'b0;
         end
         HZ_BRANCH: begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
         end
         HZ_LOAD_USE: begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
         end
         HZ_JUMP: begin
            ifid_flush_s = 1'b1;
         end
         HZ_NONE: begin
            pc_en_s = 1'b1;
         end
         default: begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            ifid_flush_s = 1'b1;
            idex_en_s    = 1'b0;
            idex_flush_s = 1'b1;
            exmem_en_s   = 1'b0;
         end
      endcase
   end

   // Next ID/EX entry and its forwarding selects; a bubble never forwards
   always_comb begin
      adv_en_s  = ~freeze_s;
      issue_s   = hz.id_valid & ~idex_flush_s;
      sb_d_s[0] = {issue_s, hz.id_dst, hz.id_reg_write, hz.id_mem_to_reg, hz.id_mem_access};
      sb_d_s[1] = sb_r[0];
      sb_d_s[2] = sb_r[1];
      if (issue_s) begin
         fwd_a_d_s = fwd_pick(src_hit(ex_valid_s, ex_rw_s, ex_dst_s, hz.id_rs),
                              src_hit(mem_valid_s, mem_rw_s, mem_dst_s, hz.id_rs));
         fwd_b_d_s = fwd_pick(hz.id_uses_rt & src_hit(ex_valid_s, ex_rw_s, ex_dst_s, hz.id_rt),
                              hz.id_uses_rt & src_hit(mem_valid_s, mem_rw_s, mem_dst_s, hz.id_rt));
      end else begin
         fwd_a_d_s = FWD_REG;
         fwd_b_d_s = FWD_REG;
      end
   end

   hazard_sb_stage #(.W(SB_W)) u_ex_e (
      .clk(clk), .clr(rst), .en(adv_en_s), .d(sb_d_s[0]), .q(sb_r[0])
   );

   hazard_sb_stage #(.W(SB_W)) u_mem_e (
      .clk(clk), .clr(rst), .en(adv_en_s), .d(sb_d_s[1]), .q(sb_r[1])
   );

   hazard_sb_stage #(.W(SB_W)) u_wb_e (
      .clk(clk), .clr(rst), .en(adv_en_s), .d(sb_d_s[2]), .q(sb_r[2])
   );

   // Forwarding selects travel with the ex_e entry and hold during a freeze
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_a_r <= FWD_REG;
         fwd_b_r <= FWD_REG;
      end else if (adv_en_s) begin
         fwd_a_r <= fwd_a_d_s;
         fwd_b_r <= fwd_b_d_s;
      end
   end

   // Count every non-reset cycle in which the PC is held
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_r <= {CNT_W{1'b0}};
      end else if (!pc_en_s) begin
         stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign hz.pc_en        = pc_en_s;
   assign hz.ifid_en      = ifid_en_s;
   assign hz.ifid_flush   = ifid_flush_s;
   assign hz.idex_en      = idex_en_s;
   assign hz.idex_flush   = idex_flush_s;
   assign hz.exmem_en     = exmem_en_s;
   assign hz.fwd_a        = fwd_a_r;
   assign hz.fwd_b        = fwd_b_r;
   assign hz.stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues one instruction per cycle
// and queues the expected controls; a monitor compares them mid-cycle.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();
   pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(bus));

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
   localparam logic [5:0] EN_RUN = 6'b110101;
   localparam logic [5:0] EN_RST = 6'b001010;
   localparam logic [5:0] EN_FRZ = 6'b000000;
   localparam logic [5:0] EN_BR  = 6'b111111;
   localparam logic [5:0] EN_LU  = 6'b000111;
   localparam logic [5:0] EN_J   = 6'b111101;

   typedef struct {
      string       nm;
      logic [5:0]  en;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   logic       nx_v, nx_u, nx_rw, nx_mtr, nx_ma, nx_j;
   logic [4:0] nx_rs, nx_rt, nx_dst;

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic u, input logic [4:0] dst, input logic rw,
                         input logic mtr, input logic ma, input logic j);
      nx_v = v; nx_rs = rs; nx_rt = rt; nx_u = u; nx_dst = dst;
      nx_rw = rw; nx_mtr = mtr; nx_ma = ma; nx_j = j;
   endtask

   task automatic nop();                                      set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
   task automatic rtype(input logic [4:0] rs, rt, dst);       set_id(1'b1, rs, rt, 1'b1, dst, 1'b1, 1'b0, 1'b0, 1'b0);    endtask
   task automatic lw(input logic [4:0] rs, dst);              set_id(1'b1, rs, dst, 1'b0, dst, 1'b1, 1'b1, 1'b1, 1'b0);   endtask
   task automatic bne(input logic [4:0] rs, rt);              set_id(1'b1, rs, rt, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);   endtask
   task automatic jmp();                                      set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

   // One pipeline cycle: apply inputs just after the edge, queue what must be seen
   task automatic cyc(input string nm, input logic r, input logic br, input logic rdy,
                      input logic [5:0] en, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] st);
      exp_t e;
      @(posedge clk);
      #2;
      rst                   = r;
      bus.ex_branch_taken   = br;
      bus.dmem_ready        = rdy;
      bus.id_valid          = nx_v;
      bus.id_rs             = nx_rs;
      bus.id_rt             = nx_rt;
      bus.id_uses_rt        = nx_u;
      bus.id_dst            = nx_dst;
      bus.id_reg_write      = nx_rw;
      bus.id_mem_to_reg     = nx_mtr;
      bus.id_mem_access     = nx_ma;
      bus.id_jump           = nx_j;
      e.nm = nm; e.en = en; e.fa = fa; e.fb = fb; e.st = st;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the DUT controls against the oldest queued expectation
   initial begin
      exp_t       m;
      logic [5:0] got_en;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            m      = exp_q.pop_front();
            got_en = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush, bus.exmem_en};
            checks++;
            if (got_en !== m.en) begin
               failures++;
               $display("FAIL %s enables: got %b want %b", m.nm, got_en, m.en);
            end
            checks++;
            if ({bus.fwd_a, bus.fwd_b} !== {m.fa, m.fb}) begin
               failures++;
               $display("FAIL %s fwd_a/fwd_b: got %b/%b want %b/%b", m.nm, bus.fwd_a, bus.fwd_b, m.fa, m.fb);
            end
            checks++;
            if (bus.stall_cycles !== m.st) begin
               failures++;
               $display("FAIL %s stall_cycles: got %0d want %0d", m.nm, bus.stall_cycles, m.st);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ex_branch_taken = 1'b0;
      bus.dmem_ready      = 1'b1;
      bus.id_valid        = 1'b0;
      bus.id_rs           = 5'd0;
      bus.id_rt           = 5'd0;
      bus.id_uses_rt      = 1'b0;
      bus.id_dst          = 5'd0;
      bus.id_reg_write    = 1'b0;
      bus.id_mem_to_reg   = 1'b0;
      bus.id_mem_access   = 1'b0;
      bus.id_jump         = 1'b0;

      nop();            cyc("rst0",       1'b1, 1'b0, 1'b1, EN_RST, 2'b00, 2'b00, 32'd0);
      nop();            cyc("rst1",       1'b1, 1'b0, 1'b1, EN_RST, 2'b00, 2'b00, 32'd0);
      // add $3 then sub $4,$3,$5
      rtype(1, 2, 3);   cyc("add3",       1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      rtype(3, 5, 4);   cyc("sub_dep",    1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      nop();            cyc("fwd_ex_a",   1'b0, 1'b0, 1'b1, EN_RUN, 2'b01, 2'b00, 32'd0);
      // add $3, unrelated I-type (rt=3 but not read), or $6,$2,$3
      rtype(1, 2, 3);   cyc("add3_b",     1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      set_id(1'b1, 5'd7, 5'd3, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
                        cyc("imm_no_rt",  1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      rtype(2, 3, 6);   cyc("or_dep",     1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      nop();            cyc("fwd_wb_b",   1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b10, 32'd0);
      // lw $2 then add $4,$2,$2: one bubble, then forward from MEM/WB
      lw(1, 2);         cyc("lw2",        1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      rtype(2, 2, 4);   cyc("load_use",   1'b0, 1'b0, 1'b1, EN_LU,  2'b00, 2'b00, 32'd0);
      rtype(2, 2, 4);   cyc("lu_resume",  1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd1);
      nop();            cyc("lu_fwd",     1'b0, 1'b0, 1'b1, EN_RUN, 2'b10, 2'b10, 32'd1);
      // lw $5 stalls 3 cycles in MEM; scoreboard must survive the freeze
      lw(1, 5);         cyc("lw5",        1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd1);
      rtype(1, 1, 9);   cyc("or9",        1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd1);
      rtype(9, 5, 10);  cyc("freeze1",    1'b0, 1'b0, 1'b0, EN_FRZ, 2'b00, 2'b00, 32'd1);
      rtype(9, 5, 10);  cyc("freeze2",    1'b0, 1'b0, 1'b0, EN_FRZ, 2'b00, 2'b00, 32'd2);
      rtype(9, 5, 10);  cyc("freeze3",    1'b0, 1'b0, 1'b0, EN_FRZ, 2'b00, 2'b00, 32'd3);
      rtype(9, 5, 10);  cyc("unfreeze",   1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      nop();            cyc("frz_fwd",    1'b0, 1'b0, 1'b1, EN_RUN, 2'b01, 2'b10, 32'd4);
      // bne taken squashes the lw in ID; its consumer then runs without a bubble
      bne(1, 2);        cyc("bne",        1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      lw(1, 11);        cyc("br_taken",   1'b0, 1'b1, 1'b1, EN_BR,  2'b00, 2'b00, 32'd4);
      rtype(11, 11, 12);cyc("post_br",    1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      // taken branch outranks a load-use match on the same cycle
      lw(1, 13);        cyc("lw13",       1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      rtype(13, 1, 14); cyc("br_over_lu", 1'b0, 1'b1, 1'b1, EN_BR,  2'b00, 2'b00, 32'd4);
      nop();            cyc("br_after",   1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      // lw $0 followed by a reader of $0 is not a hazard
      lw(1, 0);         cyc("lw0",        1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      rtype(0, 0, 15);  cyc("use_r0",     1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      nop();            cyc("r0_fwd",     1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      // jump, then a dependent pair, then reset mid-stream
      jmp();            cyc("jump",       1'b0, 1'b0, 1'b1, EN_J,   2'b00, 2'b00, 32'd4);
      rtype(1, 2, 3);   cyc("post_j",     1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      rtype(3, 3, 4);   cyc("dep_ab",     1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd4);
      nop();            cyc("mid_rst",    1'b1, 1'b0, 1'b1, EN_RST, 2'b01, 2'b01, 32'd4);
      rtype(3, 4, 5);   cyc("after_rst",  1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      nop();            cyc("rst_clear",  1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);
      nop();            cyc("idle",       1'b0, 1'b0, 1'b1, EN_RUN, 2'b00, 2'b00, 32'd0);

      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() > 0) begin
            @(posedge clk);
         end
      end
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
